// File: rtl/main_fsm_if.sv
// -----------------------------------------------------------------------------
// main_fsm_if
// Bundle between the multicycle control sequencer and the RV32I datapath.
//   master : the sequencer (main_fsm) - takes op/mem_ready, drives all strobes,
//            mux selects, ALU op, immediate select, retire/illegal_op, state.
//   slave  : the datapath / memory side - drives op/mem_ready, observes controls.
// -----------------------------------------------------------------------------
interface main_fsm_if;
    logic [6:0] op;
    logic       mem_ready;
    logic       PCUpdate;
    logic       IRWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       Branch;
    logic       AdrSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ALUOp;
    logic [1:0] ImmSrc;
    logic       retire;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  op, mem_ready,
        output PCUpdate, IRWrite, RegWrite, MemWrite, Branch, AdrSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ALUOp, ImmSrc, retire,
               illegal_op, state
    );

    modport slave (
        output op, mem_ready,
        input  PCUpdate, IRWrite, RegWrite, MemWrite, Branch, AdrSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ALUOp, ImmSrc, retire,
               illegal_op, state
    );
endinterface

// File: rtl/main_fsm.sv
// -----------------------------------------------------------------------------
// main_fsm
// Multicycle Moore control sequencer for the RV32I core. Steps one instruction
// through fetch/decode/execute/memory/writeback in 3-5 cycles; mem_ready
// stretches FETCH, MEMREAD and MEMWRITE.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low
//   bus    : main_fsm_if.master - op/mem_ready in, datapath controls out
// Parameter:
//   RESET_TRAP : 1 = illegal opcode parks in TRAP until reset,
//                0 = illegal opcode is dropped and FETCH resumes.
// -----------------------------------------------------------------------------
module main_fsm #(
    parameter bit RESET_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    main_fsm_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    // Moore control word. fetch_gate / memw_gate mark the states whose
    // IRWrite+PCUpdate or retire are qualified by mem_ready outside the flops.
    typedef struct packed {
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       pc_update;
        logic       retire;
        logic       illegal_op;
        logic       fetch_gate;
        logic       memw_gate;
    } ctrl_t;

    function automatic ctrl_t decode(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
                c.fetch_gate = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                c.adr_src = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
                c.retire     = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
                c.memw_gate = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b10;
            end
            S_EXECI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = 2'b10;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
                c.retire    = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b01;
                c.branch    = 1'b1;
                c.retire    = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.pc_update = 1'b1;
            end
            S_TRAP: begin
                c.illegal_op = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t state_q, state_d;
    ctrl_t  ctrl_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BEQ:            state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = RESET_TRAP ? S_TRAP : S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
    end

    // The control word is registered alongside the state so every Moore
    // output comes straight from a flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            ctrl_q  <= decode(S_FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode(state_d);
        end
    end

    // FETCH keeps its gate bit during reset so the mux selects show FETCH
    // values; the reset term keeps IRWrite/PCUpdate low until reset releases.
    logic fetch_hit;
    assign fetch_hit = reset & ctrl_q.fetch_gate & bus.mem_ready;

    assign bus.PCUpdate   = ctrl_q.pc_update | fetch_hit;
    assign bus.IRWrite    = fetch_hit;
    assign bus.RegWrite   = ctrl_q.reg_write;
    assign bus.MemWrite   = ctrl_q.mem_write;
    assign bus.Branch     = ctrl_q.branch;
    assign bus.AdrSrc     = ctrl_q.adr_src;
    assign bus.ALUSrcA    = ctrl_q.alu_src_a;
    assign bus.ALUSrcB    = ctrl_q.alu_src_b;
    assign bus.ResultSrc  = ctrl_q.result_src;
    assign bus.ALUOp      = ctrl_q.alu_op;
    assign bus.retire     = ctrl_q.retire | (ctrl_q.memw_gate & bus.mem_ready);
    assign bus.illegal_op = ctrl_q.illegal_op;
    assign bus.state      = state_q;

    // Immediate format select straight from the opcode.
    always_comb begin
        bus.ImmSrc = 2'b00;
        case (bus.op)
            OP_STORE: bus.ImmSrc = 2'b01;
            OP_BEQ:   bus.ImmSrc = 2'b10;
            OP_JAL:   bus.ImmSrc = 2'b11;
            default:  bus.ImmSrc = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_main_fsm.sv
// -----------------------------------------------------------------------------
// tb_main_fsm
// Two sequencers share op/mem_ready: dut0 (illegal opcode = no-op) and dut1
// (illegal opcode traps). A table of {op, mem_ready, expected state} rows is
// driven through a scoreboard; expected outputs per state come from exp_vec.
// Hand sequences cover mid-instruction reset and the trap/reset path.
// -----------------------------------------------------------------------------
module tb_main_fsm;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset0, reset1;
    logic [6:0] op_r;
    logic       mr_r;

    always #5 clk = ~clk;

    main_fsm_if if0 ();
    main_fsm_if if1 ();
    assign if0.op = op_r;
    assign if0.mem_ready = mr_r;
    assign if1.op = op_r;
    assign if1.mem_ready = mr_r;

    main_fsm #(.RESET_TRAP(1'b0)) dut0 (.clk(clk), .reset(reset0), .bus(if0));
    main_fsm #(.RESET_TRAP(1'b1)) dut1 (.clk(clk), .reset(reset1), .bus(if1));

    // {state, PCU, IRW, RW, MW, Br, Adr, A, B, Res, ALUOp, Imm, retire, illegal}
    logic [21:0] act0, act1;
    assign act0 = {if0.state, if0.PCUpdate, if0.IRWrite, if0.RegWrite, if0.MemWrite,
                   if0.Branch, if0.AdrSrc, if0.ALUSrcA, if0.ALUSrcB, if0.ResultSrc,
                   if0.ALUOp, if0.ImmSrc, if0.retire, if0.illegal_op};
    assign act1 = {if1.state, if1.PCUpdate, if1.IRWrite, if1.RegWrite, if1.MemWrite,
                   if1.Branch, if1.AdrSrc, if1.ALUSrcA, if1.ALUSrcB, if1.ResultSrc,
                   if1.ALUOp, if1.ImmSrc, if1.retire, if1.illegal_op};

    int checks = 0;
    int errors = 0;
    int rcnt   = 0;

    function automatic logic [21:0] exp_vec(logic [3:0] st, logic [6:0] op, logic mr);
        logic pcu, irw, rw, mw, br, adr, ret, ill;
        logic [1:0] a, b, r, alu, imm;
        {pcu, irw, rw, mw, br, adr, ret, ill} = '0;
        {a, b, r, alu} = '0;
        case (st)
            4'd0:  begin b = 2'b10; r = 2'b10; pcu = mr; irw = mr; end
            4'd1:  begin a = 2'b01; b = 2'b01; end
            4'd2:  begin a = 2'b10; b = 2'b01; end
            4'd3:  begin adr = 1'b1; end
            4'd4:  begin r = 2'b01; rw = 1'b1; ret = 1'b1; end
            4'd5:  begin adr = 1'b1; mw = 1'b1; ret = mr; end
            4'd6:  begin a = 2'b10; alu = 2'b10; end
            4'd7:  begin a = 2'b10; b = 2'b01; alu = 2'b10; end
            4'd8:  begin rw = 1'b1; ret = 1'b1; end
            4'd9:  begin a = 2'b10; alu = 2'b01; br = 1'b1; ret = 1'b1; end
            4'd10: begin a = 2'b01; b = 2'b10; pcu = 1'b1; end
            4'd11: begin ill = 1'b1; end
            default: ;
        endcase
        case (op)
            SW:      imm = 2'b01;
            BQ:      imm = 2'b10;
            JL:      imm = 2'b11;
            default: imm = 2'b00;
        endcase
        return {st, pcu, irw, rw, mw, br, adr, a, b, r, alu, imm, ret, ill};
    endfunction

    typedef struct {
        logic        sel;
        logic [21:0] exp;
        string       name;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [6:0] op;
        logic       mr;
        logic [3:0] st;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input logic sel, input logic [21:0] exp, input string nm);
        logic [21:0] act;
        act = sel ? act1 : act0;
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One cycle: drive inputs after the edge, push expectation, compare at negedge.
    task automatic step(input logic sel, input logic [6:0] op, input logic mr,
                        input logic [3:0] st, input string nm);
        sb_t e;
        @(posedge clk);
        #1;
        op_r = op;
        mr_r = mr;
        sb.push_back('{sel, exp_vec(st, op, mr), nm});
        @(negedge clk);
        e = sb.pop_front();
        chk(e.sel, e.exp, e.name);
        if (!sel && act0[1]) rcnt++;
    endtask

    initial begin
        reset0 = 1'b0;
        reset1 = 1'b0;
        op_r   = LW;
        mr_r   = 1'b1;

        // lw, no stall
        tbl.push_back('{LW, 1'b1, 4'd0}); tbl.push_back('{LW, 1'b1, 4'd1});
        tbl.push_back('{LW, 1'b1, 4'd2}); tbl.push_back('{LW, 1'b1, 4'd3});
        tbl.push_back('{LW, 1'b1, 4'd4});
        // sw, mem_ready low 3 cycles in MEMWRITE
        tbl.push_back('{SW, 1'b1, 4'd0}); tbl.push_back('{SW, 1'b1, 4'd1});
        tbl.push_back('{SW, 1'b1, 4'd2}); tbl.push_back('{SW, 1'b0, 4'd5});
        tbl.push_back('{SW, 1'b0, 4'd5}); tbl.push_back('{SW, 1'b0, 4'd5});
        tbl.push_back('{SW, 1'b1, 4'd5});
        // beq then jal
        tbl.push_back('{BQ, 1'b1, 4'd0}); tbl.push_back('{BQ, 1'b1, 4'd1});
        tbl.push_back('{BQ, 1'b1, 4'd9});
        tbl.push_back('{JL, 1'b1, 4'd0}); tbl.push_back('{JL, 1'b1, 4'd1});
        tbl.push_back('{JL, 1'b1, 4'd10}); tbl.push_back('{JL, 1'b1, 4'd8});
        // R-type with 2-cycle FETCH stall
        tbl.push_back('{RT, 1'b0, 4'd0}); tbl.push_back('{RT, 1'b0, 4'd0});
        tbl.push_back('{RT, 1'b1, 4'd0}); tbl.push_back('{RT, 1'b1, 4'd1});
        tbl.push_back('{RT, 1'b1, 4'd6}); tbl.push_back('{RT, 1'b1, 4'd8});
        // I-type
        tbl.push_back('{IT, 1'b1, 4'd0}); tbl.push_back('{IT, 1'b1, 4'd1});
        tbl.push_back('{IT, 1'b1, 4'd7}); tbl.push_back('{IT, 1'b1, 4'd8});
        // lw with 1-cycle MEMREAD stall
        tbl.push_back('{LW, 1'b1, 4'd0}); tbl.push_back('{LW, 1'b1, 4'd1});
        tbl.push_back('{LW, 1'b1, 4'd2}); tbl.push_back('{LW, 1'b0, 4'd3});
        tbl.push_back('{LW, 1'b1, 4'd3}); tbl.push_back('{LW, 1'b1, 4'd4});
        // illegal opcode as no-op; park in FETCH afterwards
        tbl.push_back('{BAD, 1'b1, 4'd0}); tbl.push_back('{BAD, 1'b1, 4'd1});
        tbl.push_back('{BAD, 1'b0, 4'd0});

        // Reset state: strobes low even with mem_ready high, FETCH selects.
        repeat (2) @(negedge clk);
        chk(1'b0, exp_vec(4'd0, LW, 1'b0), "reset0");
        chk(1'b1, exp_vec(4'd0, LW, 1'b0), "reset1");
        mr_r   = 1'b0;
        reset0 = 1'b1;

        foreach (tbl[i])
            step(1'b0, tbl[i].op, tbl[i].mr, tbl[i].st, $sformatf("tbl[%0d]", i));

        checks++;
        if (rcnt != 7) begin
            errors++;
            $display("FAIL retire_count: got %0d expected 7", rcnt);
        end

        // Reset asserted mid-EXECR aborts the instruction.
        step(1'b0, RT, 1'b1, 4'd0, "mid_fetch");
        step(1'b0, RT, 1'b1, 4'd1, "mid_decode");
        step(1'b0, RT, 1'b1, 4'd6, "mid_execr");
        #1 reset0 = 1'b0;
        #1 chk(1'b0, exp_vec(4'd0, RT, 1'b0), "mid_rst_async");
        @(negedge clk);
        chk(1'b0, exp_vec(4'd0, RT, 1'b0), "mid_rst_held");
        mr_r   = 1'b0;
        reset0 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk(1'b0, exp_vec(4'd0, RT, 1'b0), $sformatf("post_rst_idle%0d", k));
        end

        // Trapping variant: illegal opcode parks in TRAP until reset.
        mr_r   = 1'b0;
        reset1 = 1'b1;
        step(1'b1, BAD, 1'b1, 4'd0, "trap_fetch");
        step(1'b1, BAD, 1'b1, 4'd1, "trap_decode");
        for (int k = 0; k < 20; k++)
            step(1'b1, BAD, k[0], 4'd11, $sformatf("trap_hold%0d", k));
        #1 reset1 = 1'b0;
        #1 chk(1'b1, exp_vec(4'd0, BAD, 1'b0), "trap_reset");
        @(negedge clk);
        mr_r   = 1'b0;
        reset1 = 1'b1;
        step(1'b1, BAD, 1'b0, 4'd0, "trap_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
